// File: rtl/humidity_pkg.sv
// Shared constants, widths and FSM state type for the humidity setpoint to ADC threshold converter.
package humidity_pkg;

    localparam int unsigned HUM_W             = 10;
    localparam int unsigned H_W               = 11;
    localparam int unsigned ADC_W             = 12;
    localparam int unsigned HYST_W            = 7;
    localparam int unsigned HUM_MAX_C         = 1000;
    localparam int unsigned CODE_OFFSET_C     = 2000;
    localparam int unsigned CODE_GAIN_SHIFT_C = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLAMP = 2'd1,
        CONV  = 2'd2,
        HOLD  = 2'd3
    } state_e;

endpackage

// File: rtl/hum_code_conv.sv
// Combinational humidity (tenths %RH) to ADC code mapping: offset + gain-shifted humidity.
module hum_code_conv
    import humidity_pkg::*;
(
    input  logic [H_W-1:0]   h_i,
    output logic [ADC_W-1:0] code_c_o
);

    // Largest input after clamping is 1000, so the result never exceeds 4000 and fits 12 bits.
    always_comb begin
        code_c_o = ADC_W'(CODE_OFFSET_C) + (ADC_W'(h_i) << CODE_GAIN_SHIFT_C);
    end

endmodule

// File: rtl/humidity_to_voltage.sv
// Converts a humidity setpoint and hysteresis half-band into low/high ADC threshold codes.
// Optional build macro HUM_LIVE_CMP_EN adds a live comparator driving humid_on from voltage.
module humidity_to_voltage
    import humidity_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sp_valid,
    output logic              sp_ready,
    input  logic [HUM_W-1:0]  sp_humidity,
    input  logic [HYST_W-1:0] sp_hyst,
    output logic              th_valid,
    input  logic              th_ready,
    output logic [ADC_W-1:0]  th_low,
    output logic [ADC_W-1:0]  th_high,
`ifdef HUM_LIVE_CMP_EN
    input  logic [ADC_W-1:0]  voltage,
    output logic              humid_on,
`endif
    output logic              err_clamped
);

    state_e              state_q, state_d;
    logic [HUM_W-1:0]    hum_q, hum_d;
    logic [HYST_W-1:0]   hyst_q, hyst_d;
    logic [H_W-1:0]      h_lo_q, h_lo_d;
    logic [H_W-1:0]      h_hi_q, h_hi_d;
    logic                clamp_q, clamp_d;
    logic [ADC_W-1:0]    th_low_q, th_low_d;
    logic [ADC_W-1:0]    th_high_q, th_high_d;
    logic                th_valid_q, th_valid_d;
    logic                err_q, err_d;
    logic                sp_ready_q, sp_ready_d;

    logic [H_W-1:0]      h_c;
    logic [H_W-1:0]      sum_c;
    logic [ADC_W-1:0]    code_lo_c;
    logic [ADC_W-1:0]    code_hi_c;

`ifdef HUM_LIVE_CMP_EN
    logic                armed_q, armed_d;
    logic [ADC_W-1:0]    shadow_lo_q, shadow_lo_d;
    logic [ADC_W-1:0]    shadow_hi_q, shadow_hi_d;
    logic                humid_on_q, humid_on_d;
`endif

    hum_code_conv u_conv_lo (
        .h_i      (h_lo_q),
        .code_c_o (code_lo_c)
    );

    hum_code_conv u_conv_hi (
        .h_i      (h_hi_q),
        .code_c_o (code_hi_c)
    );

    // State and datapath registers; reset discards any in-flight setpoint.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hum_q      <= '0;
            hyst_q     <= '0;
            h_lo_q     <= '0;
            h_hi_q     <= '0;
            clamp_q    <= 1'b0;
            th_low_q   <= '0;
            th_high_q  <= '0;
            th_valid_q <= 1'b0;
            err_q      <= 1'b0;
            sp_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            hum_q      <= hum_d;
            hyst_q     <= hyst_d;
            h_lo_q     <= h_lo_d;
            h_hi_q     <= h_hi_d;
            clamp_q    <= clamp_d;
            th_low_q   <= th_low_d;
            th_high_q  <= th_high_d;
            th_valid_q <= th_valid_d;
            err_q      <= err_d;
            sp_ready_q <= sp_ready_d;
        end
    end

    // Next-state and datapath: capture, clamp/saturate, convert, hold until consumed.
    always_comb begin
        state_d    = state_q;
        hum_d      = hum_q;
        hyst_d     = hyst_q;
        h_lo_d     = h_lo_q;
        h_hi_d     = h_hi_q;
        clamp_d    = clamp_q;
        th_low_d   = th_low_q;
        th_high_d  = th_high_q;
        th_valid_d = th_valid_q;
        err_d      = err_q;

        // 11-bit intermediates: h + hyst peaks at 1127, no overflow.
        h_c   = (hum_q > HUM_W'(HUM_MAX_C)) ? H_W'(HUM_MAX_C) : H_W'(hum_q);
        sum_c = h_c + H_W'(hyst_q);

        case (state_q)
            IDLE: begin
                if (sp_valid) begin
                    hum_d   = sp_humidity;
                    hyst_d  = sp_hyst;
                    state_d = CLAMP;
                end
            end
            CLAMP: begin
                clamp_d = (hum_q > HUM_W'(HUM_MAX_C));
                h_lo_d  = (h_c >= H_W'(hyst_q)) ? (h_c - H_W'(hyst_q)) : '0;
                h_hi_d  = (sum_c > H_W'(HUM_MAX_C)) ? H_W'(HUM_MAX_C) : sum_c;
                state_d = CONV;
            end
            CONV: begin
                th_low_d   = code_lo_c;
                th_high_d  = code_hi_c;
                err_d      = clamp_q;
                th_valid_d = 1'b1;
                state_d    = HOLD;
            end
            HOLD: begin
                if (th_ready) begin
                    th_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sp_ready_d = (state_d == IDLE);
    end

`ifdef HUM_LIVE_CMP_EN
    // Live comparator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q     <= 1'b0;
            shadow_lo_q <= '0;
            shadow_hi_q <= '0;
            humid_on_q  <= 1'b0;
        end else begin
            armed_q     <= armed_d;
            shadow_lo_q <= shadow_lo_d;
            shadow_hi_q <= shadow_hi_d;
            humid_on_q  <= humid_on_d;
        end
    end

    // Shadow the last transferred thresholds and run hysteretic on/off control once armed.
    always_comb begin
        armed_d     = armed_q;
        shadow_lo_d = shadow_lo_q;
        shadow_hi_d = shadow_hi_q;
        humid_on_d  = 1'b0;

        if (armed_q) begin
            humid_on_d = humid_on_q;
            if (voltage < shadow_lo_q) begin
                humid_on_d = 1'b1;
            end else if (voltage > shadow_hi_q) begin
                humid_on_d = 1'b0;
            end
        end

        if (th_valid_q && th_ready) begin
            armed_d     = 1'b1;
            shadow_lo_d = th_low_q;
            shadow_hi_d = th_high_q;
        end
    end

    assign humid_on = humid_on_q;
`endif

    assign sp_ready    = sp_ready_q;
    assign th_valid    = th_valid_q;
    assign th_low      = th_low_q;
    assign th_high     = th_high_q;
    assign err_clamped = err_q;

endmodule

// File: tb/tb_humidity_to_voltage.sv
// Directed self-checking bench for humidity_to_voltage (live comparator checks under HUM_LIVE_CMP_EN).
module tb_humidity_to_voltage;

    logic        clk;
    logic        rst_n;
    logic        sp_valid;
    logic        sp_ready;
    logic [9:0]  sp_humidity;
    logic [6:0]  sp_hyst;
    logic        th_valid;
    logic        th_ready;
    logic [11:0] th_low;
    logic [11:0] th_high;
    logic        err_clamped;
`ifdef HUM_LIVE_CMP_EN
    logic [11:0] voltage;
    logic        humid_on;
`endif

    int total;
    int bad;

    humidity_to_voltage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sp_valid    (sp_valid),
        .sp_ready    (sp_ready),
        .sp_humidity (sp_humidity),
        .sp_hyst     (sp_hyst),
        .th_valid    (th_valid),
        .th_ready    (th_ready),
        .th_low      (th_low),
        .th_high     (th_high),
`ifdef HUM_LIVE_CMP_EN
        .voltage     (voltage),
        .humid_on    (humid_on),
`endif
        .err_clamped (err_clamped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer a setpoint for exactly one rising edge; returns at the negedge after acceptance.
    task automatic issue(input logic [9:0] sp, input logic [6:0] hy);
        @(negedge clk);
        sp_valid    = 1'b1;
        sp_humidity = sp;
        sp_hyst     = hy;
        @(negedge clk);
        sp_valid    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sp_valid = 1'b1;
        sp_humidity = 10'd500;
        sp_hyst = 7'd20;
        th_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (th_valid !== 1'b0) begin bad++; $display("FAIL reset_th_valid got=%b want=0", th_valid); end
        total++; if (th_low !== 12'h000) begin bad++; $display("FAIL reset_th_low got=%h want=000", th_low); end
        total++; if (th_high !== 12'h000) begin bad++; $display("FAIL reset_th_high got=%h want=000", th_high); end
        total++; if (err_clamped !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err_clamped); end
        total++; if (sp_ready !== 1'b1) begin bad++; $display("FAIL reset_sp_ready got=%b want=1", sp_ready); end
        sp_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (sp_ready !== 1'b1 || th_valid !== 1'b0) begin
            bad++; $display("FAIL reset_no_capture sp_ready=%b th_valid=%b want 1/0", sp_ready, th_valid);
        end
    endtask

`ifdef HUM_LIVE_CMP_EN
    task automatic test_live_unarmed();
        voltage = 12'h000;
        repeat (3) @(negedge clk);
        total++; if (humid_on !== 1'b0) begin bad++; $display("FAIL live_unarmed got=%b want=0", humid_on); end
    endtask
`endif

    task automatic test_basic();
        th_ready = 1'b1;
        issue(10'd500, 7'd20);
        total++; if (sp_ready !== 1'b0 || th_valid !== 1'b0) begin
            bad++; $display("FAIL basic_edge1 sp_ready=%b th_valid=%b want 0/0", sp_ready, th_valid);
        end
        @(negedge clk);
        total++; if (th_valid !== 1'b0) begin bad++; $display("FAIL basic_edge2_valid got=%b want=0", th_valid); end
        @(negedge clk);
        total++; if (th_valid !== 1'b1) begin bad++; $display("FAIL basic_edge3_valid got=%b want=1", th_valid); end
        total++; if (th_low !== 12'hB90) begin bad++; $display("FAIL basic_low got=%h want=b90", th_low); end
        total++; if (th_high !== 12'hBE0) begin bad++; $display("FAIL basic_high got=%h want=be0", th_high); end
        total++; if (err_clamped !== 1'b0) begin bad++; $display("FAIL basic_err got=%b want=0", err_clamped); end
        @(negedge clk);
        total++; if (sp_ready !== 1'b1 || th_valid !== 1'b0) begin
            bad++; $display("FAIL basic_return sp_ready=%b th_valid=%b want 1/0", sp_ready, th_valid);
        end
        total++; if (th_low !== 12'hB90) begin bad++; $display("FAIL basic_low_kept got=%h want=b90", th_low); end
    endtask

    task automatic test_clamp();
        th_ready = 1'b1;
        issue(10'd1023, 7'd10);
        repeat (2) @(negedge clk);
        total++; if (th_valid !== 1'b1) begin bad++; $display("FAIL clamp_valid got=%b want=1", th_valid); end
        total++; if (th_low !== 12'hF8C) begin bad++; $display("FAIL clamp_low got=%h want=f8c", th_low); end
        total++; if (th_high !== 12'hFA0) begin bad++; $display("FAIL clamp_high got=%h want=fa0", th_high); end
        total++; if (err_clamped !== 1'b1) begin bad++; $display("FAIL clamp_err got=%b want=1", err_clamped); end
        @(negedge clk);
    endtask

    task automatic test_saturate();
        th_ready = 1'b1;
        issue(10'd5, 7'd20);
        repeat (2) @(negedge clk);
        total++; if (th_low !== 12'h7D0) begin bad++; $display("FAIL sat_low got=%h want=7d0", th_low); end
        total++; if (th_high !== 12'h802) begin bad++; $display("FAIL sat_high got=%h want=802", th_high); end
        total++; if (err_clamped !== 1'b0) begin bad++; $display("FAIL sat_err got=%b want=0", err_clamped); end
        @(negedge clk);
        issue(10'd1000, 7'd0);
        repeat (2) @(negedge clk);
        total++; if (th_low !== 12'hFA0 || th_high !== 12'hFA0) begin
            bad++; $display("FAIL max_zero_hyst low=%h high=%h want fa0/fa0", th_low, th_high);
        end
        total++; if (err_clamped !== 1'b0) begin bad++; $display("FAIL max_err got=%b want=0", err_clamped); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        th_ready = 1'b0;
        issue(10'd700, 7'd5);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            sp_valid    = (i % 3 == 0);
            sp_humidity = 10'd100;
            sp_hyst     = 7'd0;
            @(negedge clk);
            total++; if (th_valid !== 1'b1 || sp_ready !== 1'b0 || th_low !== 12'hD3E || th_high !== 12'hD52) begin
                bad++; $display("FAIL bp_hold cyc=%0d valid=%b ready=%b low=%h high=%h want 1/0/d3e/d52",
                                i, th_valid, sp_ready, th_low, th_high);
            end
        end
        sp_valid = 1'b0;
        th_ready = 1'b1;
        @(negedge clk);
        total++; if (th_valid !== 1'b0 || sp_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release valid=%b ready=%b want 0/1", th_valid, sp_ready);
        end
        repeat (3) @(negedge clk);
        total++; if (th_valid !== 1'b0 || sp_ready !== 1'b1 || th_low !== 12'hD3E) begin
            bad++; $display("FAIL bp_no_capture valid=%b ready=%b low=%h want 0/1/d3e", th_valid, sp_ready, th_low);
        end
    endtask

    task automatic test_reset_mid();
        th_ready = 1'b1;
        issue(10'd1023, 7'd10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (th_valid !== 1'b0 || th_low !== 12'h000 || th_high !== 12'h000 || err_clamped !== 1'b0 || sp_ready !== 1'b1) begin
            bad++; $display("FAIL rst_mid valid=%b low=%h high=%h err=%b ready=%b want 0/000/000/0/1",
                            th_valid, th_low, th_high, err_clamped, sp_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (th_valid !== 1'b0 || sp_ready !== 1'b1) begin
            bad++; $display("FAIL rst_mid_discard valid=%b ready=%b want 0/1", th_valid, sp_ready);
        end
        issue(10'd300, 7'd0);
        repeat (2) @(negedge clk);
        total++; if (th_valid !== 1'b1 || th_low !== 12'hA28 || th_high !== 12'hA28) begin
            bad++; $display("FAIL rst_mid_after valid=%b low=%h high=%h want 1/a28/a28", th_valid, th_low, th_high);
        end
        @(negedge clk);
    endtask

`ifdef HUM_LIVE_CMP_EN
    task automatic test_live();
        voltage  = 12'h000;
        th_ready = 1'b1;
        issue(10'd500, 7'd20);
        repeat (3) @(negedge clk);
        voltage = 12'hB00;
        @(negedge clk);
        total++; if (humid_on !== 1'b1) begin bad++; $display("FAIL live_below got=%b want=1", humid_on); end
        voltage = 12'hBB8;
        @(negedge clk);
        total++; if (humid_on !== 1'b1) begin bad++; $display("FAIL live_band got=%b want=1", humid_on); end
        voltage = 12'hC00;
        @(negedge clk);
        total++; if (humid_on !== 1'b0) begin bad++; $display("FAIL live_above got=%b want=0", humid_on); end
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        sp_valid = 1'b0;
        sp_humidity = '0;
        sp_hyst = '0;
        th_ready = 1'b0;
`ifdef HUM_LIVE_CMP_EN
        voltage = 12'h000;
`endif
        test_reset();
`ifdef HUM_LIVE_CMP_EN
        test_live_unarmed();
`endif
        test_basic();
        test_clamp();
        test_saturate();
        test_backpressure();
        test_reset_mid();
`ifdef HUM_LIVE_CMP_EN
        test_live();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
